fp_norm_round_seq: RTL and testbench
====================================

Name: fp_norm_round_seq

Overview:
Multi-cycle normalize-and-round stage sitting directly downstream of the ALU stage and upstream of Pack in the FP adder datapath.
- Accepts the raw signed-magnitude sum (sign, biased exponent, extended mantissa with guard/round/sticky) and produces a packed IEEE-754 single.
- Normalizes iteratively, rounds to nearest-even, and handles overflow, subnormal and special-value results.
- Uses a valid/ready handshake on both sides so it can be dropped into a pipelined adder.

Parameters:
SHIFT_STEP, 1, maximum left-shift bits per SHIFT cycle (legal: 1, 2, 4).
EXP_W, 10, internal exponent width (headroom for carry/underflow).

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  stage can accept
in_sign  input  1  result sign (zero-sign already resolved by ALU)
in_exp  input  EXP_W  biased exponent of larger operand (1..254; subnormals presented as 1)
in_mant  input  28  [27]=carry, [26]=hidden, [25:3]=fraction, [2]=G, [1]=R, [0]=S
in_is_nan  input  1  result must be NaN
in_is_inf  input  1  result must be infinity of in_sign
out_valid  output  1  result valid
out_ready  input  1  consumer accepts
out_result  output  32  packed IEEE single

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=32'h0.
- Reset is honoured in any state, mid-operation included. A pending result is discarded and the stage is in IDLE on the next cycle.
- States: IDLE, SHIFT, ROUND, DONE.
- in_ready=1 only in IDLE. A beat is accepted when in_valid&&in_ready at the clock edge.
- IDLE capture:
  - in_is_nan: result 32'h7FC00000, go to DONE.
  - in_is_inf: result {sign,8'hFF,23'h0}, go to DONE.
  - in_mant==0: result {in_sign,31'h0}, go to DONE.
  - in_mant[27]=1: right shift by 1 with S |= shifted-out bit, exp+1, go to SHIFT.
  - Otherwise: go to SHIFT unchanged.
- SHIFT:
  - If mant[26]=1 or exp==1, go to ROUND.
  - Else left shift by k=min(SHIFT_STEP, leading zeros above bit26, exp-1), with exp-=k, and stay in SHIFT.
  - S is held sticky and zeros are shifted in.
- ROUND (RNE):
  - Increment = G && (R || S || L), where L=mant[3].
  - Add the increment at bit3.
  - If the result carries into bit27: right shift 1, exp+1.
  - If hidden was 0 and becomes 1 with exp==1: result is normal with exp field 1.
  - Exp field = (hidden ? exp : 0).
  - If exp>=255: result {sign,8'hFF,23'h0}.
  - Go to DONE.
- DONE:
  - out_valid=1; out_result is registered and stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; the next beat can be accepted in the cycle after.
- Latency (accepting cycle = 0):
  - Specials and zero: out_valid in cycle 1.
  - Otherwise: out_valid in cycle 3 + number of shift cycles.
- Throughput: one result in flight; no bypass.

Optional Feature:
FPNORM_FLAGS_EN:
- Defined: adds output out_flags[3:0] = {invalid, overflow, underflow, inexact}, registered with out_result and valid with out_valid.
  - inexact = any of G/R/S nonzero before rounding, or overflow.
  - underflow = tiny (exp field 0) && inexact.
  - invalid = in_is_nan.
- Undefined: the port and all flag logic are absent; other behaviour is identical.

Decomposition:
- Package fpnorm_pkg holds:
  - the state enum;
  - mantissa bit-position constants (CARRY=27, HIDDEN=26, LSB=3);
  - EXP_MAX=255, QNAN=32'h7FC00000;
  - the captured-operand struct type.
- Sub-module fp_rne_round: combinational RNE increment, carry renormalization and overflow-to-infinity. It is instantiated once in ROUND.

Test Plan:
- exp=128, mant=28'h8000000 (4.0 with carry) -> 32'h40800000, out_valid in cycle 3.
- exp=127, mant=28'h0000008 (cancellation) -> 32'h34000000 after 23 shift cycles (cycle 26) with SHIFT_STEP=1; cycle 9 with SHIFT_STEP=4.
- Tie cases, both from exp=127:
  - mant=28'h400000C -> 32'h3F800002 (round up to even).
  - mant=28'h4000004 -> 32'h3F800000 (stays even).
- Overflow and subnormal:
  - exp=254, mant=28'hFFFFFF0 -> 32'h7F800000.
  - exp=1, mant=28'h0000008 -> 32'h00000001 with no shift cycles.
  - exp=1, mant=28'h3FFFFFC -> 32'h00800000 (round into normal).
- Specials:
  - in_is_nan=1 -> 32'h7FC00000.
  - in_is_inf=1, in_sign=1 -> 32'hFF800000.
  - Both in cycle 1.
- Handshake and reset:
  - out_ready=0 for 5 cycles -> out_result stable, in_ready=0.
  - reset asserted mid-SHIFT -> next cycle out_valid=0, in_ready=1, and no stale result emerges.

Source files
------------

// File: rtl/fpnorm_pkg.sv
// Shared types and constants for the FP normalize-and-round stage.
package fpnorm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Bit positions inside the 28-bit extended mantissa
  localparam int CARRY  = 27;
  localparam int HIDDEN = 26;
  localparam int LSB    = 3;

  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [27:0] mant;
  } operand_t;

endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even, carry renormalization and overflow-to-infinity.
// Optional flag outputs exist only when FPNORM_FLAGS_EN is defined.
module fp_rne_round
  import fpnorm_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [27:0]      mant_i,
  output logic [31:0]      result_o
`ifdef FPNORM_FLAGS_EN
  ,
  output logic             inexact_o,
  output logic             overflow_o,
  output logic             tiny_o
`endif
);

  localparam logic [EXP_W:0] EXP_MAX_W = (EXP_W+1)'(EXP_MAX);

  logic           inc;
  logic [24:0]    m_up;
  logic           carry;
  logic           hidden;
  logic [22:0]    frac;
  logic [EXP_W:0] exp_adj;
  logic           ovf;
  logic [7:0]     exp_field;

  always_comb begin
    inc       = mant_i[2] & (mant_i[1] | mant_i[0] | mant_i[LSB]);
    m_up      = mant_i[CARRY:LSB] + {24'b0, inc};
    carry     = m_up[24];
    // A subnormal that rounds up into bit 26 becomes the smallest normal
    hidden    = carry | m_up[23];
    frac      = carry ? m_up[23:1] : m_up[22:0];
    exp_adj   = {1'b0, exp_i} + {{EXP_W{1'b0}}, carry};
    ovf       = (exp_adj >= EXP_MAX_W);
    exp_field = hidden ? exp_adj[7:0] : 8'h00;
    result_o  = ovf ? {sign_i, 8'hFF, 23'h0} : {sign_i, exp_field, frac};
  end

`ifdef FPNORM_FLAGS_EN
  assign inexact_o  = (|mant_i[2:0]) | ovf;
  assign overflow_o = ovf;
  assign tiny_o     = ~hidden & ~ovf;
`endif

endmodule

// File: rtl/fp_norm_round_seq.sv
// Multi-cycle normalize/round stage: iterative left shift, RNE rounding, specials.
// Define FPNORM_FLAGS_EN to add out_flags = {invalid, overflow, underflow, inexact}.
module fp_norm_round_seq
  import fpnorm_pkg::*;
#(
  parameter int SHIFT_STEP = 1,
  parameter int EXP_W      = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [27:0]      in_mant,
  input  logic             in_is_nan,
  input  logic             in_is_inf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result
`ifdef FPNORM_FLAGS_EN
  ,
  output logic [3:0]       out_flags
`endif
);

  state_e           state_q, state_d;
  operand_t         op_q, op_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [31:0]      result_q, result_d;
  logic [2:0]       k;
  logic [31:0]      rnd_result;

`ifdef FPNORM_FLAGS_EN
  logic [3:0] flags_q, flags_d;
  logic       rnd_inexact, rnd_overflow, rnd_tiny;
`endif

  fp_rne_round #(.EXP_W(EXP_W)) u_round (
    .sign_i     (op_q.sign),
    .exp_i      (exp_q),
    .mant_i     (op_q.mant),
    .result_o   (rnd_result)
`ifdef FPNORM_FLAGS_EN
    ,
    .inexact_o  (rnd_inexact),
    .overflow_o (rnd_overflow),
    .tiny_o     (rnd_tiny)
`endif
  );

  // Shift amount: limited by step size, leading zeros above bit 26, and exp-1
  always_comb begin
    k = 3'd0;
    for (int i = 1; i <= SHIFT_STEP; i++) begin
      if (k == 3'(i - 1) && !op_q.mant[HIDDEN + 1 - i] && exp_q > EXP_W'(i))
        k = 3'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    exp_d    = exp_q;
    result_d = result_q;
`ifdef FPNORM_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_is_nan) begin
            result_d = QNAN;
            state_d  = ST_DONE;
`ifdef FPNORM_FLAGS_EN
            flags_d  = 4'b1000;
`endif
          end else if (in_is_inf || in_mant == 28'd0) begin
            result_d = in_is_inf ? {in_sign, 8'hFF, 23'h0} : {in_sign, 31'h0};
            state_d  = ST_DONE;
`ifdef FPNORM_FLAGS_EN
            flags_d  = 4'b0000;
`endif
          end else if (in_mant[CARRY]) begin
            op_d.sign = in_sign;
            op_d.mant = {1'b0, in_mant[27:2], in_mant[1] | in_mant[0]};
            exp_d     = in_exp + EXP_W'(1);
            state_d   = ST_SHIFT;
          end else begin
            op_d.sign = in_sign;
            op_d.mant = in_mant;
            exp_d     = in_exp;
            state_d   = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (op_q.mant[HIDDEN] || exp_q == EXP_W'(1)) begin
          state_d = ST_ROUND;
        end else begin
          // Sticky bit stays set while zeros enter from the bottom
          op_d.mant = (op_q.mant << k) | {27'b0, op_q.mant[0]};
          exp_d     = exp_q - EXP_W'(k);
        end
      end
      ST_ROUND: begin
        result_d = rnd_result;
        state_d  = ST_DONE;
`ifdef FPNORM_FLAGS_EN
        flags_d  = {1'b0, rnd_overflow, rnd_tiny & rnd_inexact, rnd_inexact};
`endif
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      exp_q    <= '0;
      result_q <= 32'h0;
`ifdef FPNORM_FLAGS_EN
      flags_q  <= 4'h0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      exp_q    <= exp_d;
      result_q <= result_d;
`ifdef FPNORM_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
`ifdef FPNORM_FLAGS_EN
  assign out_flags  = flags_q;
`endif

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// Directed-vector bench for fp_norm_round_seq (SHIFT_STEP=1 and a SHIFT_STEP=4 copy).
module tb_fp_norm_round_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_valid4;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        in_is_nan, in_is_inf;
  logic        out_ready;
  logic        in_ready, out_valid;
  logic [31:0] out_result;
  logic        in_ready4, out_valid4;
  logic [31:0] out_result4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_norm_round_seq #(.SHIFT_STEP(1), .EXP_W(10)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_is_nan(in_is_nan), .in_is_inf(in_is_inf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  fp_norm_round_seq #(.SHIFT_STEP(4), .EXP_W(10)) dut4 (
    .clock(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_is_nan(in_is_nan), .in_is_inf(in_is_inf),
    .out_valid(out_valid4), .out_ready(1'b1), .out_result(out_result4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the result handed off (if out_ready).
  task automatic run_vec(input string tag, input bit use4, input logic s, input logic [9:0] e,
                         input logic [27:0] m, input logic nan, input logic inf,
                         input logic [31:0] want, input int want_lat);
    int cyc;
    bit seen;
    cyc = 0;
    while (!(use4 ? in_ready4 : in_ready) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    in_sign = s; in_exp = e; in_mant = m; in_is_nan = nan; in_is_inf = inf;
    if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    cyc = 1; seen = 1'b0;
    while (cyc < 100) begin
      if (use4 ? out_valid4 : out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_valid"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(want_lat));
    chk({tag, "_res"}, use4 ? out_result4 : out_result, want);
    $display("vec %-12s exp=%0d mant=%h -> %h (want %h) latency %0d (want %0d)",
             tag, e, m, use4 ? out_result4 : out_result, want, cyc, want_lat);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] held;
    bit stale;
    reset = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; in_sign = 1'b0;
    in_exp = '0; in_mant = '0; in_is_nan = 1'b0; in_is_inf = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_vec("four_carry", 0, 1'b0, 10'd128, 28'h8000000, 0, 0, 32'h40800000, 3);
    run_vec("cancel", 0, 1'b0, 10'd127, 28'h0000008, 0, 0, 32'h34000000, 26);
    run_vec("cancel_s4", 1, 1'b0, 10'd127, 28'h0000008, 0, 0, 32'h34000000, 9);
    run_vec("tie_up", 0, 1'b0, 10'd127, 28'h400000C, 0, 0, 32'h3F800002, 3);
    run_vec("tie_even", 0, 1'b0, 10'd127, 28'h4000004, 0, 0, 32'h3F800000, 3);
    run_vec("ovf_carry", 0, 1'b0, 10'd254, 28'hFFFFFF0, 0, 0, 32'h7F800000, 3);
    run_vec("ovf_round", 0, 1'b0, 10'd254, 28'h7FFFFFC, 0, 0, 32'h7F800000, 3);
    run_vec("sub_min", 0, 1'b0, 10'd1, 28'h0000008, 0, 0, 32'h00000001, 3);
    run_vec("sub_to_norm", 0, 1'b0, 10'd1, 28'h3FFFFFC, 0, 0, 32'h00800000, 3);
    run_vec("shift_clamp", 0, 1'b0, 10'd3, 28'h0400000, 0, 0, 32'h00200000, 5);
    run_vec("neg_norm", 0, 1'b1, 10'd130, 28'h6000000, 0, 0, 32'hC1400000, 3);
    run_vec("nan", 0, 1'b0, 10'd100, 28'h4000000, 1, 0, 32'h7FC00000, 1);
    run_vec("neg_inf", 0, 1'b1, 10'd100, 28'h4000000, 0, 1, 32'hFF800000, 1);
    run_vec("neg_zero", 0, 1'b1, 10'd5, 28'h0000000, 0, 0, 32'h80000000, 1);

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    run_vec("stall", 0, 1'b0, 10'd127, 28'h4000004, 0, 0, 32'h3F800000, 3);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", out_result, 32'h3F800000);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    $display("vec stall        held %h for 5 cycles", held);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 32'(in_ready), 32'd1);

    // Reset in the middle of a long normalization
    in_sign = 1'b0; in_exp = 10'd127; in_mant = 28'h0000008; in_is_nan = 1'b0; in_is_inf = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", out_result, 32'h0);
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);
    $display("vec midrst       reset during SHIFT, stale=%0d", stale);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
